// File: rtl/mem_access_master.sv
// MEM-stage load/store bus initiator: alignment/range check, one word-aligned bus
// transfer with byte enables, load-data extraction and timeout reporting.
module mem_access_master #(
    parameter logic [31:0] DM_BYTES = 32'h4000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_width,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_lo;
    logic [1:0]    r_width;
    logic          r_sext;
    logic [31:0]   r_rdata;
    logic          r_rdata_valid;
    logic          r_bus_err;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [3:0]    r_bus_be;
    logic [31:0]   r_bus_wdata;

    logic          w_bad;
    logic          w_start;
    logic          w_ack;
    logic          w_tmo;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;

    // Address error: reserved width, misaligned half/word, or outside the data space
    assign w_bad = (req_width == 2'b11)
                 | ((req_width == W_HALF) & req_addr[0])
                 | ((req_width == W_WORD) & (req_addr[1:0] != 2'b00))
                 | (req_addr >= DM_BYTES);

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_ack   = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && !w_bad) begin
                    w_start = 1'b1;
                    w_next  = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    w_ack  = 1'b1;
                    w_next = ST_DONE;
                end else if (r_timer == TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Stall covers the issuing IDLE cycle and the whole bus wait; released in DONE
    assign stall    = reset & (((r_state == ST_IDLE) & req_valid & ~w_bad) | (r_state == ST_BUS));
    assign exc_adel = (r_state == ST_IDLE) & req_valid & w_bad & ~req_store;
    assign exc_ades = (r_state == ST_IDLE) & req_valid & w_bad & req_store;

    // Store lane placement
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        if (req_store) begin
            case (req_width)
                W_BYTE: begin
                    w_be    = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                W_HALF: begin
                    w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load lane extraction and extension
    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_lo)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_width)
            W_HALF:  w_ext = {{16{r_sext & w_half[15]}}, w_half};
            W_BYTE:  w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
            default: w_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer       <= '0;
            r_lo          <= '0;
            r_width       <= '0;
            r_sext        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_bus_err     <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wdata   <= '0;
        end else begin
            r_rdata_valid <= w_ack | w_tmo;
            r_bus_err     <= w_tmo;
            r_bus_req     <= (w_next == ST_BUS);
            if (w_start) begin
                r_timer     <= '0;
                r_lo        <= req_addr[1:0];
                r_width     <= req_width;
                r_sext      <= req_sext;
                r_bus_we    <= req_store;
                r_bus_addr  <= {req_addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata;
            end else if ((r_state == ST_BUS) && !bus_ack) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_ack) begin
                r_rdata <= r_bus_we ? 32'h0 : w_ext;
            end else if (w_tmo) begin
                r_rdata <= 32'h0;
            end
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign bus_err     = r_bus_err;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_be      = r_bus_be;
    assign bus_wdata   = r_bus_wdata;

endmodule
